// File: rtl/pc_gen_stage.sv
// Pre-IF stage: owns the fetch PC, issues instruction-SRAM requests and hands
// {pc, pred_pc} to IF, redirecting on branch-unit cancels.
module pc_gen_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        br_taken_cancel,
   input  logic [31:0] br_target,
   output logic        inst_sram_req,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        fs_allowin,
   output logic        to_fs_valid,
   output logic [31:0] to_fs_pc,
   output logic [31:0] to_fs_pred_pc,
   output logic        fetch_discard
);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_HAND} state_t;

   state_t      state, state_next;
   logic [31:0] fetch_pc, fetch_pc_next;
   logic [31:0] redir_pc, redir_pc_next;
   logic        redir_vld, redir_vld_next;
   logic        discard_next;
   logic        hand_load;

   assign inst_sram_addr = fetch_pc;

   always_comb begin
      state_next     = state;
      fetch_pc_next  = fetch_pc;
      redir_pc_next  = redir_pc;
      redir_vld_next = redir_vld;
      discard_next   = 1'b0;
      hand_load      = 1'b0;
      inst_sram_req  = 1'b0;
      to_fs_valid    = 1'b0;

      if (br_taken_cancel && state != S_BOOT)
         redir_pc_next = br_target;

      case (state)
         S_BOOT: state_next = S_REQ;
         S_REQ: begin
            inst_sram_req = 1'b1;
            if (inst_sram_addr_ok) begin
               // A cancel arriving with the handshake supersedes any parked target.
               if (br_taken_cancel) begin
                  fetch_pc_next  = br_target;
                  redir_vld_next = 1'b0;
                  discard_next   = 1'b1;
               end else if (redir_vld) begin
                  fetch_pc_next  = redir_pc;
                  redir_vld_next = 1'b0;
                  discard_next   = 1'b1;
               end else begin
                  hand_load  = 1'b1;
                  state_next = S_HAND;
               end
            end else if (br_taken_cancel) begin
               redir_vld_next = 1'b1;
            end
         end
         S_HAND: begin
            if (br_taken_cancel) begin
               fetch_pc_next = br_target;
               discard_next  = 1'b1;
               state_next    = S_REQ;
            end else begin
               to_fs_valid = 1'b1;
               if (fs_allowin) begin
                  fetch_pc_next = fetch_pc + PC_INC;
                  state_next    = S_REQ;
               end
            end
         end
         default: state_next = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_BOOT;
         fetch_pc      <= RESET_PC;
         redir_pc      <= 32'd0;
         redir_vld     <= 1'b0;
         fetch_discard <= 1'b0;
         to_fs_pc      <= 32'd0;
         to_fs_pred_pc <= 32'd0;
      end else begin
         state         <= state_next;
         fetch_pc      <= fetch_pc_next;
         redir_pc      <= redir_pc_next;
         redir_vld     <= redir_vld_next;
         fetch_discard <= discard_next;
         if (hand_load) begin
            to_fs_pc      <= fetch_pc;
            to_fs_pred_pc <= fetch_pc + PC_INC;
         end
      end
   end

endmodule
